// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: widths, halt word, reset defaults,
// fetch state encoding and the fetch address legality check.
package instr_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] HALT_WORD = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES_DEF = 1024;

  typedef enum logic [1:0] {
    FS_RUN,
    FS_HALT_PEND,
    FS_HALTED,
    FS_FAULT
  } fetch_state_e;

  // A fetch is legal only when word aligned and all four bytes lie inside the ROM.
  // The sum is done in 33 bits so an address near 2^32 cannot wrap into range.
  function automatic logic fetch_addr_bad(input logic [XLEN-1:0] addr,
                                          input int unsigned imem_bytes);
    return (addr[1:0] != 2'b00) ||
           (({1'b0, addr} + 33'd3) >= {1'b0, imem_bytes});
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// IF/ID handshake bundle between the fetch stage (master) and the decoder (slave).
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  // valid/ready: a slot transfers on a cycle where id_valid && id_ready; the master
  // holds id_pc/id_inst/id_pc_plus4 stable while id_valid && !id_ready, and may
  // refill the slot in the same cycle it transfers.
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc_plus4;

  modport master (output id_valid, id_pc, id_inst, id_pc_plus4, input id_ready);
  modport slave  (input id_valid, id_pc, id_inst, id_pc_plus4, output id_ready);

endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: one instruction slot with load, flush and stall hold.
module if_id_reg
  import instr_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_inst,
  instr_fetch_if.master   id
);

  // Flush beats load; without a load the slot empties once the decoder takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id.id_valid    <= 1'b0;
      id.id_pc       <= '0;
      id.id_inst     <= '0;
      id.id_pc_plus4 <= '0;
    end else if (flush) begin
      id.id_valid <= 1'b0;
    end else if (load) begin
      id.id_valid    <= 1'b1;
      id.id_pc       <= load_pc;
      id.id_inst     <= load_inst;
      id.id_pc_plus4 <= load_pc + 32'd4;
    end else if (id.id_ready) begin
      id.id_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses the instruction ROM, fills the IF/ID slot,
// and handles redirects, the halt word and fetch faults.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned     IMEM_BYTES = IMEM_BYTES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_inst,
  input  logic            imem_pc_en,
  instr_fetch_if.master   id,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            pipe_empty,
  output logic            halted,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr,
  output logic [XLEN-1:0] fetch_count,
  output fetch_state_e    fetch_state
);

  logic [XLEN-1:0] pc;
  fetch_state_e    state;
  logic            redirect_bad;
  logic            pc_bad;
  logic            slot_free;
  logic            flush;
  logic            load;

  assign imem_addr    = pc;
  assign fetch_state  = state;
  assign redirect_bad = fetch_addr_bad(redirect_target, IMEM_BYTES);
  assign pc_bad       = fetch_addr_bad(pc, IMEM_BYTES);
  assign slot_free    = !id.id_valid || id.id_ready;

  always_comb begin
    flush = 1'b0;
    load  = 1'b0;
    case (state)
      FS_RUN: begin
        if (redirect_valid || pc_bad) flush = 1'b1;
        else if (slot_free && imem_pc_en) load = 1'b1;
      end
      FS_HALT_PEND: flush = redirect_valid;
      default: ;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (load),
    .load_pc   (pc),
    .load_inst (imem_inst),
    .id        (id)
  );

  // A redirect seen in HALT_PEND means the zero word was fetched speculatively.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FS_RUN;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fault_addr  <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        FS_RUN, FS_HALT_PEND: begin
          if (redirect_valid) begin
            if (redirect_bad) begin
              state      <= FS_FAULT;
              fault      <= 1'b1;
              fault_addr <= redirect_target;
            end else begin
              state <= FS_RUN;
              pc    <= redirect_target;
            end
          end else if (state == FS_HALT_PEND) begin
            if (pipe_empty && !id.id_valid) begin
              state  <= FS_HALTED;
              halted <= 1'b1;
            end
          end else if (pc_bad) begin
            state      <= FS_FAULT;
            fault      <= 1'b1;
            fault_addr <= pc;
          end else if (slot_free) begin
            if (imem_pc_en) begin
              pc          <= pc + 32'd4;
              fetch_count <= fetch_count + 32'd1;
            end else begin
              state <= FS_HALT_PEND;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized episodes, all compared
// each cycle against a queue-based behavioural model of the fetch stage.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int unsigned ROM_BYTES = 1024;
  localparam int M_RUN = 0, M_PEND = 1, M_HALTED = 2, M_FAULT = 3;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } slot_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [31:0]  imem_addr, imem_inst;
  logic         imem_pc_en;
  logic         redirect_valid, pipe_empty;
  logic [31:0]  redirect_target;
  logic         halted, fault;
  logic [31:0]  fault_addr, fetch_count;
  fetch_state_e fetch_state;
  logic [31:0]  rom [0:255];

  instr_fetch_if id_bus ();

  instr_fetch #(.RESET_PC(32'h0), .IMEM_BYTES(ROM_BYTES)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_inst       (imem_inst),
    .imem_pc_en      (imem_pc_en),
    .id              (id_bus),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pipe_empty      (pipe_empty),
    .halted          (halted),
    .fault           (fault),
    .fault_addr      (fault_addr),
    .fetch_count     (fetch_count),
    .fetch_state     (fetch_state)
  );

  assign imem_inst  = (imem_addr < ROM_BYTES) ? rom[imem_addr[9:2]] : 32'hFFFF_FFFF;
  assign imem_pc_en = (imem_inst != 32'h0);

  // ---------------- scoreboard / model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  slot_t       slot_q[$];
  logic [31:0] m_pc, m_fault_addr, m_count;
  int          m_state;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (longint'(a) + 3 >= longint'(ROM_BYTES));
  endfunction

  task automatic model_reset();
    slot_q.delete();
    m_pc = 32'h0; m_fault_addr = 32'h0; m_count = 32'h0; m_state = M_RUN;
  endtask

  task automatic take_redirect(input logic [31:0] rt);
    slot_q.delete();
    if (addr_bad(rt)) begin
      m_state = M_FAULT;
      m_fault_addr = rt;
    end else begin
      m_pc = rt;
      m_state = M_RUN;
    end
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rt, input logic rdy,
                            input logic pe);
    logic [31:0] w;
    if (m_state == M_RUN || m_state == M_PEND) begin
      if (rv) take_redirect(rt);
      else if (m_state == M_PEND) begin
        if (slot_q.size() == 0 && pe) m_state = M_HALTED;
        else if (slot_q.size() != 0 && rdy) slot_q.delete();
      end else if (addr_bad(m_pc)) begin
        slot_q.delete();
        m_state = M_FAULT;
        m_fault_addr = m_pc;
      end else if (slot_q.size() == 0 || rdy) begin
        slot_q.delete();
        w = rom[m_pc[9:2]];
        if (w == 32'h0) m_state = M_PEND;
        else begin
          slot_q.push_back('{pc: m_pc, inst: w});
          m_pc = m_pc + 32'd4;
          m_count = m_count + 32'd1;
        end
      end
    end
  endtask

  task automatic check_all();
    check32("imem_addr", imem_addr, m_pc);
    check32("id_valid", 32'(id_bus.id_valid), 32'(slot_q.size() != 0));
    if (slot_q.size() != 0) begin
      check32("id_pc", id_bus.id_pc, slot_q[0].pc);
      check32("id_inst", id_bus.id_inst, slot_q[0].inst);
      check32("id_pc_plus4", id_bus.id_pc_plus4, slot_q[0].pc + 32'd4);
    end
    check32("halted", 32'(halted), 32'(m_state == M_HALTED));
    check32("fault", 32'(fault), 32'(m_state == M_FAULT));
    check32("fault_addr", fault_addr, m_fault_addr);
    check32("fetch_count", fetch_count, m_count);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic rv, input logic [31:0] rt, input logic rdy,
                       input logic pe);
    redirect_valid = rv; redirect_target = rt; id_bus.id_ready = rdy; pipe_empty = pe;
    model_step(rv, rt, rdy, pe);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, rdy, 1'b0);
  endtask

  // Asserts reset between edges and checks the outputs cleared before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0; id_bus.id_ready = 1'b0;
    pipe_empty = 1'b0;
    #1;
    check32("rst_id_valid", 32'(id_bus.id_valid), 32'h0);
    check32("rst_id_pc", id_bus.id_pc, 32'h0);
    check32("rst_id_inst", id_bus.id_inst, 32'h0);
    check32("rst_id_pc_plus4", id_bus.id_pc_plus4, 32'h0);
    check32("rst_imem_addr", imem_addr, 32'h0);
    check32("rst_halted", 32'(halted), 32'h0);
    check32("rst_fault", 32'(fault), 32'h0);
    check32("rst_fault_addr", fault_addr, 32'h0);
    check32("rst_fetch_count", fetch_count, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_directed_rom();
    for (int i = 0; i < 256; i++) rom[i] = $urandom | 32'h1;
    rom[0] = 32'h0090_0513;
    rom[1] = 32'h0060_0593;
    rom[2] = 32'h00b5_0633;
    rom[5] = 32'h0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    load_directed_rom();
    do_reset();

    // straight line
    run(3, 1'b1);
    check32("t1_id_pc", id_bus.id_pc, 32'h8);
    check32("t1_id_inst", id_bus.id_inst, 32'h00b5_0633);
    check32("t1_count", fetch_count, 32'd3);

    // stall at id_pc=4, release, then redirect while stalled
    do_reset();
    run(2, 1'b1);
    run(3, 1'b0);
    check32("t2_hold_pc", id_bus.id_pc, 32'h4);
    check32("t2_hold_addr", imem_addr, 32'h8);
    run(1, 1'b1);
    check32("t2_release_pc", id_bus.id_pc, 32'h8);
    run(1, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 1'b0);
    check32("t3_flush", 32'(id_bus.id_valid), 32'h0);
    check32("t3_addr", imem_addr, 32'h40);
    run(1, 1'b1);
    check32("t3_id_pc", id_bus.id_pc, 32'h40);

    // halt word at 0x14
    do_reset();
    run(6, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check32("t4_halted", 32'(halted), 32'h1);
    check32("t4_addr", imem_addr, 32'h14);
    cycle(1'b1, 32'h40, 1'b1, 1'b1);
    check32("t4_ignored", imem_addr, 32'h14);

    // redirect out of HALT_PEND
    do_reset();
    run(6, 1'b1);
    cycle(1'b1, 32'h40, 1'b1, 1'b0);
    run(1, 1'b1);
    check32("t4_resume_pc", id_bus.id_pc, 32'h40);

    // faults: misaligned target, then running off the end of the ROM
    do_reset();
    cycle(1'b1, 32'h42, 1'b1, 1'b0);
    check32("t5_fault_addr", fault_addr, 32'h42);
    run(2, 1'b1);
    do_reset();
    cycle(1'b1, 32'h3FC, 1'b1, 1'b0);
    run(2, 1'b1);
    check32("t5_end_fault", 32'(fault), 32'h1);
    check32("t5_end_addr", fault_addr, 32'h400);

    // reset mid-stall, then resume at RESET_PC
    do_reset();
    run(2, 1'b1);
    run(2, 1'b0);
    #2;
    do_reset();
    run(1, 1'b1);
    check32("t6_resume_pc", id_bus.id_pc, 32'h0);

    // randomized episodes
    for (int ep = 0; ep < 8; ep++) begin
      int idle;
      logic [31:0] tgt;
      for (int i = 0; i < 256; i++)
        rom[i] = ($urandom_range(0, 24) == 0) ? 32'h0 : ($urandom | 32'h1);
      do_reset();
      idle = 0;
      for (int c = 0; c < 250 && idle < 5; c++) begin
        case ($urandom_range(0, 7))
          0:       tgt = $urandom;
          1:       tgt = ($urandom_range(0, 255) * 4) | 32'h2;
          default: tgt = $urandom_range(0, 255) * 4;
        endcase
        cycle($urandom_range(0, 15) == 0, tgt, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0);
        if (m_state == M_HALTED || m_state == M_FAULT) idle++;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
